// File: rtl/gpio_atomic_sequencer_if.sv
// Peripheral-bus slot between the atomic sequencer (master) and the GPIO device (slave).
interface gpio_atomic_sequencer_if;
   logic        peripheralEnable;
   logic        peripheralBus_we;
   logic        peripheralBus_oe;
   logic        peripheralBus_busy;
   logic [15:0] peripheralBus_address;
   logic [3:0]  peripheralBus_byteSelect;
   logic [31:0] peripheralBus_dataWrite;
   logic [31:0] peripheralBus_dataRead;

   modport master (
      output peripheralEnable,
      output peripheralBus_we,
      output peripheralBus_oe,
      output peripheralBus_address,
      output peripheralBus_byteSelect,
      output peripheralBus_dataWrite,
      input  peripheralBus_busy,
      input  peripheralBus_dataRead
   );

   modport slave (
      input  peripheralEnable,
      input  peripheralBus_we,
      input  peripheralBus_oe,
      input  peripheralBus_address,
      input  peripheralBus_byteSelect,
      input  peripheralBus_dataWrite,
      output peripheralBus_busy,
      output peripheralBus_dataRead
   );
endinterface

// File: rtl/gpio_atomic_sequencer.sv
// Two-requester round-robin master running atomic read-modify-write bit operations
// on the GPIO OE / output registers, returning the pre-operation register value.
module gpio_atomic_sequencer #(
   parameter logic [3:0]  ID       = 4'h0,
   parameter int unsigned IO_COUNT = 16,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          req,
   input  logic [1:0]          op0,
   input  logic [1:0]          op1,
   input  logic                sel0,
   input  logic                sel1,
   input  logic [IO_COUNT-1:0] value0,
   input  logic [IO_COUNT-1:0] value1,
   output logic [1:0]          done,
   output logic                error,
   output logic [IO_COUNT-1:0] oldValue,
   gpio_atomic_sequencer_if.master bus
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
   localparam logic [1:0]  OP_WRITE  = 2'b00;
   localparam logic [1:0]  OP_SET    = 2'b01;
   localparam logic [1:0]  OP_CLEAR  = 2'b10;
   localparam logic [1:0]  OP_TOGGLE = 2'b11;
   localparam logic [11:0] LOC_OE    = 12'h000;
   localparam logic [11:0] LOC_OUT   = 12'h004;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic                ptr_q, ptr_d;
   logic                gnt_q, gnt_d;
   logic [1:0]          op_q, op_d;
   logic                sel_q, sel_d;
   logic [IO_COUNT-1:0] val_q, val_d;
   logic [IO_COUNT-1:0] old_q, old_d;
   logic [IO_COUNT-1:0] res_q, res_d;
   logic                abort_q, abort_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                en_q, en_d;
   logic                we_q, we_d;
   logic                oe_q, oe_d;
   logic [15:0]         addr_q, addr_d;
   logic [3:0]          bs_q, bs_d;
   logic [31:0]         dw_q, dw_d;
   logic [1:0]          done_q, done_d;
   logic                err_q, err_d;
   logic [IO_COUNT-1:0] oldv_q, oldv_d;

   logic                busy_c;
   logic                at_limit_c;
   logic                gnt_c;
   logic [IO_COUNT-1:0] rd_c;
   logic [IO_COUNT-1:0] modify_c;
   logic                unused_rd_c;

   assign busy_c      = bus.peripheralBus_busy;
   assign rd_c        = bus.peripheralBus_dataRead[IO_COUNT-1:0];
   assign unused_rd_c = ^bus.peripheralBus_dataRead;
   assign at_limit_c  = (cnt_q == CNT_LIMIT);
   // Preferred requester wins when requesting, otherwise the other one.
   assign gnt_c       = req[ptr_q] ? ptr_q : ~ptr_q;

   always_comb begin
      modify_c = val_q;
      unique case (op_q)
         OP_SET:    modify_c = rd_c | val_q;
         OP_CLEAR:  modify_c = rd_c & ~val_q;
         OP_TOGGLE: modify_c = rd_c ^ val_q;
         default:   modify_c = val_q;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         ptr_q    <= 1'b0;
         gnt_q    <= 1'b0;
         op_q     <= OP_WRITE;
         sel_q    <= 1'b0;
         val_q    <= '0;
         old_q    <= '0;
         res_q    <= '0;
         abort_q  <= 1'b0;
         cnt_q    <= '0;
         en_q     <= 1'b0;
         we_q     <= 1'b0;
         oe_q     <= 1'b0;
         addr_q   <= '0;
         bs_q     <= '0;
         dw_q     <= '0;
         done_q   <= '0;
         err_q    <= 1'b0;
         oldv_q   <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         op_q     <= op_d;
         sel_q    <= sel_d;
         val_q    <= val_d;
         old_q    <= old_d;
         res_q    <= res_d;
         abort_q  <= abort_d;
         cnt_q    <= cnt_d;
         en_q     <= en_d;
         we_q     <= we_d;
         oe_q     <= oe_d;
         addr_q   <= addr_d;
         bs_q     <= bs_d;
         dw_q     <= dw_d;
         done_q   <= done_d;
         err_q    <= err_d;
         oldv_q   <= oldv_d;
      end
   end

   // Next-state and sequence datapath.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      op_d    = op_q;
      sel_d   = sel_q;
      val_d   = val_q;
      old_d   = old_q;
      res_d   = res_q;
      abort_d = abort_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (|req) begin
               gnt_d   = gnt_c;
               op_d    = gnt_c ? op1 : op0;
               sel_d   = gnt_c ? sel1 : sel0;
               val_d   = gnt_c ? value1 : value0;
               old_d   = '0;
               abort_d = 1'b0;
               cnt_d   = '0;
               if (op_d == OP_WRITE) begin
                  res_d   = val_d;
                  state_d = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_READ: begin
            if (!busy_c) begin
               old_d   = rd_c;
               res_d   = modify_c;
               cnt_d   = '0;
               state_d = S_WRITE;
            end else if (at_limit_c) begin
               abort_d = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WRITE: begin
            if (!busy_c) begin
               state_d = S_DONE;
            end else if (at_limit_c) begin
               abort_d = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            ptr_d   = ~gnt_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Registered outputs follow the state being entered, so they line up with state_q.
   always_comb begin
      en_d   = (state_d == S_READ) || (state_d == S_WRITE);
      oe_d   = (state_d == S_READ);
      we_d   = (state_d == S_WRITE);
      addr_d = '0;
      bs_d   = '0;
      dw_d   = '0;
      done_d = '0;
      err_d  = 1'b0;
      oldv_d = oldv_q;

      if (en_d) begin
         addr_d = {ID, (sel_d ? LOC_OUT : LOC_OE)};
         bs_d   = 4'hF;
      end
      if (we_d) begin
         dw_d = 32'(res_d);
      end
      if (state_d == S_DONE) begin
         done_d = gnt_d ? 2'b10 : 2'b01;
         err_d  = abort_d;
         oldv_d = old_d;
      end
   end

   assign done                         = done_q;
   assign error                        = err_q;
   assign oldValue                     = oldv_q;
   assign bus.peripheralEnable         = en_q;
   assign bus.peripheralBus_we         = we_q;
   assign bus.peripheralBus_oe         = oe_q;
   assign bus.peripheralBus_address    = addr_q;
   assign bus.peripheralBus_byteSelect = bs_q;
   assign bus.peripheralBus_dataWrite  = dw_q;

endmodule

// File: tb/tb_gpio_atomic_sequencer.sv
// Self-checking bench: vector table plus hand sequences, done pulses scored against a queue.
module tb_gpio_atomic_sequencer;

   localparam int unsigned IO = 16;

   typedef struct {
      logic [1:0]  done;
      logic        err;
      logic [15:0] old;
      logic        wrote;
      logic [31:0] wdata;
      logic [15:0] addr;
      int          lat;
      int          t0;
   } exp_t;

   typedef struct {
      int          k;
      logic [1:0]  op;
      logic        sel;
      logic [15:0] val;
      logic [31:0] rd;
      int          stall;
      logic        stuck;
      logic        err;
      logic [15:0] old;
      logic        wrote;
      logic [31:0] wdata;
      logic [15:0] addr;
      int          lat;
   } vec_t;

   logic          clk;
   logic          rst;
   logic [1:0]    req;
   logic [1:0]    op0, op1;
   logic          sel0, sel1;
   logic [IO-1:0] value0, value1;
   logic [1:0]    done;
   logic          error;
   logic [IO-1:0] oldValue;

   gpio_atomic_sequencer_if bus ();

   gpio_atomic_sequencer #(.ID(4'h5), .IO_COUNT(IO), .TIMEOUT(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .op0      (op0),
      .op1      (op1),
      .sel0     (sel0),
      .sel1     (sel1),
      .value0   (value0),
      .value1   (value1),
      .done     (done),
      .error    (error),
      .oldValue (oldValue),
      .bus      (bus)
   );

   int          n_cmp;
   int          n_fail;
   int          cyc;
   int          ndone;
   exp_t        q[$];
   logic        bad;
   logic        wr_seen;
   logic [31:0] wr_data;
   logic [15:0] wr_addr;
   logic [15:0] rd_addr;
   vec_t        vecs[9];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic monitor_step();
      exp_t e;
      if (bus.peripheralEnable === 1'b1) begin
         if (bus.peripheralBus_byteSelect !== 4'hF) bad = 1'b1;
         if (bus.peripheralBus_oe && bus.peripheralBus_we) bad = 1'b1;
         if (bus.peripheralBus_oe) rd_addr = bus.peripheralBus_address;
         if (bus.peripheralBus_we && !bus.peripheralBus_busy) begin
            wr_seen = 1'b1;
            wr_data = bus.peripheralBus_dataWrite;
            wr_addr = bus.peripheralBus_address;
         end
      end else if ({bus.peripheralBus_we, bus.peripheralBus_oe, bus.peripheralBus_address,
                    bus.peripheralBus_byteSelect, bus.peripheralBus_dataWrite} !== '0) begin
         bad = 1'b1;
      end
      if (done !== 2'b00) begin
         ndone++;
         if (q.size() == 0) begin
            check("unexpected_done", 64'(done), 64'(0));
         end else begin
            e = q.pop_front();
            check("done", 64'(done), 64'(e.done));
            check("error", 64'(error), 64'(e.err));
            check("oldValue", 64'(oldValue), 64'(e.old));
            check("latency", 64'(cyc - e.t0), 64'(e.lat));
            check("write_issued", 64'(wr_seen), 64'(e.wrote));
            if (e.wrote) check("write_data", 64'(wr_data), 64'(e.wdata));
            check("address", 64'(e.wrote ? wr_addr : rd_addr), 64'(e.addr));
            check("bus_rules", 64'(bad), 64'(0));
         end
         wr_seen = 1'b0;
         bad     = 1'b0;
         rd_addr = '0;
      end
   endtask

   initial begin
      bad = 1'b0; wr_seen = 1'b0; wr_data = '0; wr_addr = '0; rd_addr = '0;
      forever begin
         @(negedge clk);
         monitor_step();
      end
   end

   task automatic wait_done(input int target, input int budget);
      for (int i = 0; i < budget && ndone < target; i++) @(posedge clk);
      if (ndone < target) begin
         n_cmp++;
         n_fail++;
         $display("FAIL done_wait: got %0d done pulses expected %0d", ndone, target);
         q.delete();
         ndone = target;
      end
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e;
      int   target;
      @(posedge clk); #1;
      if (v.k == 0) begin
         op0 = v.op; sel0 = v.sel; value0 = v.val;
         op1 = v.op ^ 2'b11; sel1 = ~v.sel; value1 = ~v.val;
      end else begin
         op1 = v.op; sel1 = v.sel; value1 = v.val;
         op0 = v.op ^ 2'b11; sel0 = ~v.sel; value0 = ~v.val;
      end
      bus.peripheralBus_dataRead = v.rd;
      bus.peripheralBus_busy     = (v.stall > 0) || v.stuck;
      req = (v.k == 0) ? 2'b01 : 2'b10;
      e.done = (v.k == 0) ? 2'b01 : 2'b10;
      e.err = v.err; e.old = v.old; e.wrote = v.wrote; e.wdata = v.wdata;
      e.addr = v.addr; e.lat = v.lat; e.t0 = cyc;
      target = ndone + 1;
      q.push_back(e);
      if (v.stall > 0) begin
         repeat (v.stall + 1) @(posedge clk);
         #1 bus.peripheralBus_busy = 1'b0;
      end
      wait_done(target, 40);
      req = 2'b00;
      bus.peripheralBus_busy = 1'b0;
      @(negedge clk);
      check("oldValue_held", 64'(oldValue), 64'(v.old));
   endtask

   // Both requesters held; releases reset on the first cycle. Grants alternate from requester 0.
   task automatic contention(input int n);
      exp_t e;
      int   target;
      @(posedge clk); #1;
      rst = 1'b1;
      op0 = 2'b01; sel0 = 1'b1; value0 = 16'h00F0;
      op1 = 2'b11; sel1 = 1'b0; value1 = 16'hFFFF;
      bus.peripheralBus_dataRead = 32'h0000_0F0F;
      bus.peripheralBus_busy     = 1'b0;
      req = 2'b11;
      target = ndone + n;
      for (int i = 0; i < n; i++) begin
         e.done  = (i % 2 == 0) ? 2'b01 : 2'b10;
         e.err   = 1'b0;
         e.old   = 16'h0F0F;
         e.wrote = 1'b1;
         e.wdata = (i % 2 == 0) ? 32'h0000_0FFF : 32'h0000_F0F0;
         e.addr  = (i % 2 == 0) ? 16'h5004 : 16'h5000;
         e.lat   = 3 + 4 * i;
         e.t0    = cyc;
         q.push_back(e);
      end
      wait_done(target, 60);
      req = 2'b00;
   endtask

   initial begin
      n_cmp = 0; n_fail = 0; ndone = 0;
      // k op sel val rd stall stuck | err old wrote wdata addr lat
      vecs[0] = '{0, 2'b01, 1'b1, 16'h0003, 32'hFFFF_00F0, 0, 1'b0, 1'b0, 16'h00F0, 1'b1, 32'h0000_00F3, 16'h5004, 3};
      vecs[1] = '{1, 2'b10, 1'b0, 16'h00FF, 32'h0000_FFFF, 0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 32'h0000_FF00, 16'h5000, 3};
      vecs[2] = '{0, 2'b11, 1'b0, 16'h8001, 32'h0000_FFFF, 0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 32'h0000_7FFE, 16'h5000, 3};
      vecs[3] = '{1, 2'b00, 1'b1, 16'hA5C3, 32'h0000_1234, 0, 1'b0, 1'b0, 16'h0000, 1'b1, 32'h0000_A5C3, 16'h5004, 2};
      vecs[4] = '{0, 2'b01, 1'b1, 16'h0100, 32'h0000_0001, 3, 1'b0, 1'b0, 16'h0001, 1'b1, 32'h0000_0101, 16'h5004, 6};
      vecs[5] = '{1, 2'b11, 1'b1, 16'h00FF, 32'h0000_1111, 0, 1'b1, 1'b1, 16'h0000, 1'b0, 32'h0000_0000, 16'h5004, 5};
      vecs[6] = '{1, 2'b01, 1'b0, 16'h0000, 32'h0000_8000, 0, 1'b0, 1'b0, 16'h8000, 1'b1, 32'h0000_8000, 16'h5000, 3};
      vecs[7] = '{0, 2'b10, 1'b1, 16'hFFFF, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 16'hBEEF, 1'b1, 32'h0000_0000, 16'h5004, 3};
      vecs[8] = '{0, 2'b00, 1'b0, 16'hFFFF, 32'h0000_0000, 2, 1'b0, 1'b0, 16'h0000, 1'b1, 32'h0000_FFFF, 16'h5000, 4};

      rst = 1'b0; req = 2'b11;
      op0 = 2'b01; sel0 = 1'b1; value0 = 16'h00F0;
      op1 = 2'b11; sel1 = 1'b0; value1 = 16'hFFFF;
      bus.peripheralBus_busy = 1'b0;
      bus.peripheralBus_dataRead = 32'h0000_0F0F;

      // Reset held two cycles with both requesting.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_ctrl", 64'({bus.peripheralEnable, bus.peripheralBus_we, bus.peripheralBus_oe,
                               bus.peripheralBus_byteSelect, bus.peripheralBus_address, done, error}), 64'(0));
      check("reset_wdata", 64'(bus.peripheralBus_dataWrite), 64'(0));
      check("reset_oldValue", 64'(oldValue), 64'(0));

      contention(3);

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // Reset while a WRITE is stalled on busy.
      @(posedge clk); #1;
      op0 = 2'b00; sel0 = 1'b1; value0 = 16'h1357;
      bus.peripheralBus_busy = 1'b1;
      req = 2'b01;
      @(posedge clk);
      @(negedge clk);
      check("midwrite_we", 64'(bus.peripheralBus_we), 64'(1));
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midwrite_rst_ctrl", 64'({bus.peripheralEnable, bus.peripheralBus_we, bus.peripheralBus_oe,
                                      bus.peripheralBus_byteSelect, bus.peripheralBus_address, done, error}), 64'(0));
      check("midwrite_rst_wdata", 64'(bus.peripheralBus_dataWrite), 64'(0));
      check("midwrite_rst_oldValue", 64'(oldValue), 64'(0));
      req = 2'b00;
      bus.peripheralBus_busy = 1'b0;

      contention(2);

      repeat (4) @(posedge clk);
      @(negedge clk);
      check("queue_empty", 64'(q.size()), 64'(0));
      check("bus_rules_final", 64'(bad), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/gpio_atomic_sequencer.md
# gpio_atomic_sequencer

Peripheral-bus master that performs atomic bit operations (write, set, clear, toggle) on the GPIO device's output-enable and output-data registers on behalf of two requesters. It arbitrates round-robin between the requesters, runs each operation as a read-modify-write bus sequence, and returns the pre-operation register value. It sits between two client masters (e.g. core-side helpers) and the GPIO device's peripheral bus slot, so a read-modify-write cannot be interleaved with the other requester's access.

## Interface
- ID, 4'h0: device ID of the target GPIO device; drives peripheralBus_address[15:12]
- IO_COUNT, 16: GPIO width, 1..32
- TIMEOUT, 255: consecutive busy cycles tolerated per bus phase before abort, 1..255

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req  in  2  per-requester request level, bit k = requester k
- op0, op1  in  2 each  operation: 00 WRITE, 01 SET, 10 CLEAR, 11 TOGGLE
- sel0, sel1  in  1 each  target: 0 = OE register (local 0x000), 1 = output register (local 0x004)
- value0, value1  in  IO_COUNT each  WRITE data, or bit mask for SET/CLEAR/TOGGLE
- done  out  2  one-cycle completion pulse, bit k = requester k
- error  out  1  valid with done; 1 = operation aborted on timeout
- oldValue  out  IO_COUNT  register value read before modification; valid with done, held until next done
- peripheralEnable  out  1  bus cycle active
- peripheralBus_we  out  1  write strobe
- peripheralBus_oe  out  1  read strobe
- peripheralBus_busy  in  1  slave busy
- peripheralBus_address  out  16  {ID, local address}
- peripheralBus_byteSelect  out  4  always 4'hF while enabled, else 0
- peripheralBus_dataWrite  out  32  zero-extended result
- peripheralBus_dataRead  in  32  slave read data; bits [IO_COUNT-1:0] used

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: if any req bit set, grant per round-robin pointer (pointer selects preferred requester; other wins if preferred not requesting). Latch op, sel, value of granted requester. Go to WRITE if op = WRITE, else READ. If no request, stay.
- READ: peripheralEnable=1, oe=1, address={ID, sel?12'h004:12'h000}. When busy=0, capture dataRead[IO_COUNT-1:0] into oldValue register and compute result: SET old|value, CLEAR old&~value, TOGGLE old^value; go to WRITE.
- WRITE op: no read; oldValue updated to the OE/output value as unknown is not allowed — oldValue is set to all-zeros for WRITE ops.
- WRITE: peripheralEnable=1, we=1, dataWrite={zeros, result}. When busy=0, go to DONE.
- DONE: done[granted]=1 for exactly one cycle, error reflects abort flag; round-robin pointer moves to the non-granted requester; return to IDLE.
- Timeout: 8-bit counter cleared on entry to READ and WRITE, increments each cycle busy=1. If busy=1 while counter = TIMEOUT-1, abort: go to DONE with error=1, skipping any remaining write. Register not modified on abort from READ.
- Requester contract: hold req and operands stable until done; drop req the cycle after done or a new operation is started.
- Reset (rst=0 at a clock edge, any state): state IDLE, all bus outputs 0, done=0, error=0, oldValue=0, pointer=requester 0, counter=0. An in-flight sequence is abandoned; no done pulse.

## Timing
- Bus outputs and done are registered; all bus outputs 0 in IDLE and DONE.
- Zero-wait RMW: req seen cycle 0 (IDLE), READ cycle 1, WRITE cycle 2, done cycle 3; next grant earliest cycle 4 (IDLE). Each busy cycle adds one.
- Zero-wait WRITE op: WRITE cycle 1, done cycle 2.
- Simultaneous req = 2'b11 after reset: requester 0 served first, then requester 1, alternating while both held.
- Timeout with busy stuck: error/done asserted TIMEOUT cycles after phase entry.

## Test plan
- Reset: rst=0 two cycles with req=2'b11 -> all outputs 0, no done; after release requester 0 granted first.
- SET on output register: slave returns 0x00F0, requester 0 op=SET value=0x0003 -> read at address {ID,0x004}, write 0x000000F3, done=2'b01 at cycle 3, oldValue=0x00F0, error=0.
- CLEAR/TOGGLE on OE register, slave returns 0xFFFF: CLEAR 0x00FF -> writes 0xFF00; TOGGLE 0x8001 -> writes 0x7FFE.
- Contention: req=2'b11 held, requester 0 SET, requester 1 TOGGLE -> done alternates 01,10,01; no bus cycles overlap.
- Busy stall: busy=1 for 3 cycles in READ -> done at cycle 6, error=0; busy stuck with TIMEOUT=4 -> error=1 done 4 cycles after READ entry, no write strobe issued.
- Reset mid-WRITE: rst=0 while we=1 -> next cycle all bus outputs 0, no done pulse, state IDLE.
